// File: rtl/keccak_pkg.sv
// Shared constants and encodings for the Keccak sponge controller and its datapath.
// Holds the permutation round count, lane widths, the datapath mux encodings and the FSM states.
// Also holds a small helper that maps an FSM state to the state_sel it drives.
package keccak_pkg;

  localparam int KECCAK_ROUNDS = 24;
  localparam int RATE_W        = 1088;
  localparam int STATE_W       = 1600;
  localparam int ROUND_IDX_W   = 5;

  // Datapath state mux select
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_CLEAR = 2'b01,
    SEL_XOR   = 2'b10,
    SEL_ROUND = 2'b11
  } sel_e;

  // Sponge controller states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_ABSORB   = 3'd3,
    ST_PERMUTE  = 3'd4,
    ST_DONE     = 3'd5
  } fsm_e;

  // Mux select the datapath must see while the controller sits in state s
  function automatic sel_e sel_for(input fsm_e s);
    case (s)
      ST_CLEAR:   return SEL_CLEAR;
      ST_ABSORB:  return SEL_XOR;
      ST_PERMUTE: return SEL_ROUND;
      default:    return SEL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Round-constant index counter for one Keccak-f permutation.
// Index is registered: start zeroes it, each enabled cycle advances it and wraps after the last round.
// No backpressure; o_done flags the enabled cycle that carries the final round index.
module keccak_round_counter #(
  parameter int NUM_ROUNDS = 24,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_en,
  output logic             o_done,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  logic [IDX_W-1:0] r_idx;

  // Load zero on start, otherwise step through 0..NUM_ROUNDS-1 while enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (i_start) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  assign o_done = i_en & (r_idx == LAST_IDX);
  assign o_idx  = r_idx;

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller for Keccak-256: clears state, absorbs rate blocks, sequences NUM_ROUNDS rounds each.
// Handshake-to-digest latency for a final block is NUM_ROUNDS+1 cycles; outputs are registered.
// blk_ready is high only while waiting for a block; digest is held until digest_ack; abort always wins.
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = KECCAK_ROUNDS,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_start,
  input  logic                   abort,
  input  logic                   blk_valid,
  input  logic                   blk_last,
  output logic                   blk_ready,
  output logic [1:0]             state_sel,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   digest_valid,
  input  logic                   digest_ack,
  output logic                   busy,
  output logic [CNT_W-1:0]       blk_count
);

  fsm_e                   r_state;
  fsm_e                   w_nxt_state;
  sel_e                   r_sel;
  logic                   r_blk_ready;
  logic                   r_digest_valid;
  logic                   r_busy;
  logic                   r_last;
  logic [CNT_W-1:0]       r_blk_count;
  logic                   w_hs;
  logic                   w_cnt_start;
  logic                   w_cnt_en;
  logic                   w_cnt_done;
  logic [ROUND_IDX_W-1:0] w_cnt_idx;

  // A block is taken only in WAIT_BLK, and an abort in the same cycle cancels it
  assign w_hs        = (r_state == ST_WAIT_BLK) & blk_valid & ~abort;
  // Counter is held at zero outside PERMUTE so every permutation starts from round 0
  assign w_cnt_start = (r_state != ST_PERMUTE);
  assign w_cnt_en    = (r_state == ST_PERMUTE);

  keccak_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (ROUND_IDX_W)
  ) u_round_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_cnt_start),
    .i_en    (w_cnt_en),
    .o_done  (w_cnt_done),
    .o_idx   (w_cnt_idx)
  );

  // Next-state decision; abort overrides every other input outside IDLE
  always_comb begin
    w_nxt_state = r_state;
    if (r_state != ST_IDLE && abort) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (msg_start) w_nxt_state = ST_CLEAR;
        ST_CLEAR:    w_nxt_state = ST_WAIT_BLK;
        ST_WAIT_BLK: if (blk_valid) w_nxt_state = ST_ABSORB;
        ST_ABSORB:   w_nxt_state = ST_PERMUTE;
        ST_PERMUTE:  if (w_cnt_done) w_nxt_state = r_last ? ST_DONE : ST_WAIT_BLK;
        ST_DONE: begin
          if (digest_ack) w_nxt_state = msg_start ? ST_CLEAR : ST_IDLE;
        end
        default:     w_nxt_state = ST_IDLE;
      endcase
    end
  end

  // State register with outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_sel          <= SEL_HOLD;
      r_blk_ready    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_last         <= 1'b0;
      r_blk_count    <= '0;
    end else begin
      r_state        <= w_nxt_state;
      r_sel          <= sel_for(w_nxt_state);
      r_blk_ready    <= (w_nxt_state == ST_WAIT_BLK);
      r_digest_valid <= (w_nxt_state == ST_DONE);
      r_busy         <= (w_nxt_state != ST_IDLE);
      if (w_hs) begin
        r_last <= blk_last;
      end
      if (r_state == ST_CLEAR) begin
        r_blk_count <= '0;
      end else if (r_state == ST_ABSORB && r_blk_count != {CNT_W{1'b1}}) begin
        r_blk_count <= r_blk_count + 1'b1;
      end
    end
  end

  assign blk_ready    = r_blk_ready;
  assign state_sel    = r_sel;
  assign round_idx    = (r_state == ST_PERMUTE) ? w_cnt_idx : '0;
  assign digest_valid = r_digest_valid;
  assign busy         = r_busy;
  assign blk_count    = r_blk_count;

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are observed at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_keccak_sponge_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_start = 1'b0;
  logic        abort = 1'b0;
  logic        blk_valid = 1'b0;
  logic        blk_last = 1'b0;
  logic        blk_ready;
  logic [1:0]  state_sel;
  logic [4:0]  round_idx;
  logic        digest_valid;
  logic        digest_ack = 1'b0;
  logic        busy;
  logic [15:0] blk_count;

  int n_tests = 0;
  int n_fail  = 0;

  keccak_sponge_ctrl #(.NUM_ROUNDS(24), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .msg_start    (msg_start),
    .abort        (abort),
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .state_sel    (state_sel),
    .round_idx    (round_idx),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack),
    .busy         (busy),
    .blk_count    (blk_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse msg_start from IDLE, leaving the DUT in WAIT_BLK
  task automatic start_msg();
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
    tick();
  endtask

  // Offer one block for a single cycle (DUT assumed in WAIT_BLK)
  task automatic send_block(input logic last);
    blk_valid = 1'b1;
    blk_last  = last;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b0 || blk_ready !== 1'b0 || digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b blk_ready=%b digest_valid=%b, required 0/0/0", busy, blk_ready, digest_valid);
    end
    n_tests++;
    if (state_sel !== 2'b00 || round_idx !== 5'd0 || blk_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_vals: state_sel=%b round_idx=%0d blk_count=%0d, required 00/0/0", state_sel, round_idx, blk_count);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_block();
    int bad_rounds = 0;
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
    n_tests++;
    if (state_sel !== 2'b01 || busy !== 1'b1 || blk_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_clear: state_sel=%b busy=%b blk_ready=%b, required 01/1/0", state_sel, busy, blk_ready);
    end
    tick();
    n_tests++;
    if (state_sel !== 2'b00 || blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait: state_sel=%b blk_ready=%b, required 00/1", state_sel, blk_ready);
    end
    send_block(1'b1);
    n_tests++;
    if (state_sel !== 2'b10 || blk_ready !== 1'b0 || round_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL single_absorb: state_sel=%b blk_ready=%b round_idx=%0d, required 10/0/0", state_sel, blk_ready, round_idx);
    end
    for (int r = 0; r < 24; r++) begin
      tick();
      if (state_sel !== 2'b11 || round_idx !== 5'(r) || digest_valid !== 1'b0 || blk_ready !== 1'b0)
        bad_rounds++;
    end
    n_tests++;
    if (bad_rounds != 0) begin
      n_fail++;
      $display("FAIL single_rounds: %0d round cycles wrong (last state_sel=%b round_idx=%0d), required 0", bad_rounds, state_sel, round_idx);
    end
    tick();
    n_tests++;
    if (digest_valid !== 1'b1 || state_sel !== 2'b00 || blk_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_done: digest_valid=%b state_sel=%b blk_count=%0d, required 1/00/1", digest_valid, state_sel, blk_count);
    end
    tick();
    tick();
    n_tests++;
    if (digest_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: digest_valid=%b busy=%b, required 1/1", digest_valid, busy);
    end
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || digest_valid !== 1'b0 || blk_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_ack: busy=%b digest_valid=%b blk_count=%0d, required 0/0/1", busy, digest_valid, blk_count);
    end
  endtask

  task automatic test_multi_block();
    int low_cycles;
    int dv_seen = 0;
    start_msg();
    for (int b = 0; b < 3; b++) begin
      n_tests++;
      if (blk_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL multi_ready_b%0d: blk_ready=%b, required 1", b, blk_ready);
      end
      send_block(b == 2);
      low_cycles = 1;
      while (blk_ready !== 1'b1 && digest_valid !== 1'b1 && low_cycles < 40) begin
        // stray msg_start mid-permutation must be ignored
        msg_start = (b == 0 && low_cycles == 5);
        // a block offered during permutation must not be taken
        blk_valid = (b == 1 && low_cycles == 8);
        tick();
        msg_start = 1'b0;
        blk_valid = 1'b0;
        if (digest_valid === 1'b1) dv_seen++;
        low_cycles++;
      end
      n_tests++;
      if (low_cycles != 26) begin
        n_fail++;
        $display("FAIL multi_latency_b%0d: %0d cycles to next ready/digest, required 26 (25 low)", b, low_cycles);
      end
    end
    n_tests++;
    if (dv_seen != 1 || blk_count !== 16'd3) begin
      n_fail++;
      $display("FAIL multi_done: digest_valid entries=%0d blk_count=%0d, required 1/3", dv_seen, blk_count);
    end
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
  endtask

  task automatic test_abort();
    int cyc = 0;
    int dv_hits = 0;
    start_msg();
    send_block(1'b1);
    for (int i = 0; i < 11; i++) tick();
    n_tests++;
    if (round_idx !== 5'd10) begin
      n_fail++;
      $display("FAIL abort_setup: round_idx=%0d, required 10", round_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || state_sel !== 2'b00 || round_idx !== 5'd0 || blk_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b state_sel=%b round_idx=%0d blk_ready=%b, required 0/00/0/0", busy, state_sel, round_idx, blk_ready);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (digest_valid !== 1'b0) dv_hits++;
    end
    n_tests++;
    if (dv_hits != 0) begin
      n_fail++;
      $display("FAIL abort_no_digest: digest_valid high %0d cycles, required 0", dv_hits);
    end
    start_msg();
    send_block(1'b1);
    while (digest_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 25 || blk_count !== 16'd1) begin
      n_fail++;
      $display("FAIL abort_restart: latency=%0d blk_count=%0d, required 25/1", cyc, blk_count);
    end
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_msg();
    send_block(1'b1);
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (round_idx !== 5'd5) begin
      n_fail++;
      $display("FAIL rstmid_setup: round_idx=%0d, required 5", round_idx);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || blk_ready !== 1'b0 || state_sel !== 2'b00 || round_idx !== 5'd0 ||
        digest_valid !== 1'b0 || blk_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: busy=%b rdy=%b sel=%b idx=%0d dv=%b cnt=%0d, required 0/0/00/0/0/0",
               busy, blk_ready, state_sel, round_idx, digest_valid, blk_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (busy !== 1'b0 || round_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL rstmid_stays_idle: busy=%b round_idx=%0d, required 0/0", busy, round_idx);
    end
  endtask

  task automatic test_back_to_back();
    start_msg();
    send_block(1'b1);
    for (int i = 0; i < 25; i++) tick();
    n_tests++;
    if (digest_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done1: digest_valid=%b, required 1", digest_valid);
    end
    digest_ack = 1'b1;
    msg_start  = 1'b1;
    tick();
    digest_ack = 1'b0;
    msg_start  = 1'b0;
    n_tests++;
    if (state_sel !== 2'b01 || busy !== 1'b1 || digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_clear: state_sel=%b busy=%b digest_valid=%b, required 01/1/0", state_sel, busy, digest_valid);
    end
    tick();
    n_tests++;
    if (blk_ready !== 1'b1 || blk_count !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_wait: blk_ready=%b blk_count=%0d, required 1/0", blk_ready, blk_count);
    end
    send_block(1'b1);
    for (int i = 0; i < 25; i++) tick();
    digest_ack = 1'b1;
    msg_start  = 1'b1;
    abort      = 1'b1;
    tick();
    digest_ack = 1'b0;
    msg_start  = 1'b0;
    abort      = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || state_sel !== 2'b00 || digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_abort: busy=%b state_sel=%b digest_valid=%b, required 0/00/0", busy, state_sel, digest_valid);
    end
    // abort beats a simultaneous block offer: nothing absorbed
    start_msg();
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    abort     = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    abort     = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || state_sel !== 2'b00 || blk_count !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_vs_blk: busy=%b state_sel=%b blk_count=%0d, required 0/00/0", busy, state_sel, blk_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
